// File: rtl/bus_arbiter_if.sv
// Two-master request side plus the shared bus; the arbiter uses the slave view.
// Latency and backpressure are set by the arbiter: per-master DTAck_H marks each completed transfer.
interface bus_arbiter_if;
  logic        M0_AS_L;
  logic        M1_AS_L;
  logic        M0_WE_L;
  logic        M1_WE_L;
  logic [3:0]  M0_Byte_Enable;
  logic [3:0]  M1_Byte_Enable;
  logic [31:0] M0_Address;
  logic [31:0] M1_Address;
  logic [31:0] M0_DataOut;
  logic [31:0] M1_DataOut;
  logic        M0_DTAck_H;
  logic        M1_DTAck_H;
  logic [31:0] M0_DataIn;
  logic [31:0] M1_DataIn;
  logic        Bus_AS_L;
  logic        Bus_WE_L;
  logic [3:0]  Bus_Byte_Enable;
  logic [31:0] Bus_Address;
  logic [31:0] Bus_DataOut;
  logic [31:0] Bus_DataIn;
  logic        Slow_Select_H;
  logic [1:0]  Grant;

  modport slave (
    input  M0_AS_L, M1_AS_L, M0_WE_L, M1_WE_L,
    input  M0_Byte_Enable, M1_Byte_Enable, M0_Address, M1_Address,
    input  M0_DataOut, M1_DataOut, Bus_DataIn, Slow_Select_H,
    output M0_DTAck_H, M1_DTAck_H, M0_DataIn, M1_DataIn,
    output Bus_AS_L, Bus_WE_L, Bus_Byte_Enable, Bus_Address, Bus_DataOut, Grant
  );

  modport master (
    output M0_AS_L, M1_AS_L, M0_WE_L, M1_WE_L,
    output M0_Byte_Enable, M1_Byte_Enable, M0_Address, M1_Address,
    output M0_DataOut, M1_DataOut, Bus_DataIn, Slow_Select_H,
    input  M0_DTAck_H, M1_DTAck_H, M0_DataIn, M1_DataIn,
    input  Bus_AS_L, Bus_WE_L, Bus_Byte_Enable, Bus_Address, Bus_DataOut, Grant
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin two-master bus arbiter with region-dependent wait states; DTAck at request+1+W cycles.
// Losing master is held pending (AS_L low) until the owner releases its strobe after its ACK.
module bus_arbiter #(
  parameter int FAST_WAIT = 1,
  parameter int SLOW_WAIT = 4
) (
  input logic          Clock,
  input logic          Reset_L,
  bus_arbiter_if.slave bus
);

  localparam logic [31:0] FastW = (FAST_WAIT < 1) ? 32'd1 : 32'(FAST_WAIT);
  localparam logic [31:0] SlowW = (SLOW_WAIT < 1) ? 32'd1 : 32'(SLOW_WAIT);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK, RELEASE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_m1_q, last_m1_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_hold_q, addr_hold_d;
  logic [31:0] dout_hold_q, dout_hold_d;

  logic        req0, req1, sel_m1, own_as_l, drive_bus, sel_we_l;
  logic [3:0]  sel_be;
  logic [31:0] sel_addr, sel_dout, wait_lim;

  always_comb begin
    req0      = !bus.M0_AS_L;
    req1      = !bus.M1_AS_L;
    sel_m1    = grant_q[1];
    own_as_l  = sel_m1 ? bus.M1_AS_L : bus.M0_AS_L;
    sel_we_l  = sel_m1 ? bus.M1_WE_L : bus.M0_WE_L;
    sel_be    = sel_m1 ? bus.M1_Byte_Enable : bus.M0_Byte_Enable;
    sel_addr  = sel_m1 ? bus.M1_Address : bus.M0_Address;
    sel_dout  = sel_m1 ? bus.M1_DataOut : bus.M0_DataOut;
    drive_bus = (state_q == ACCESS) || (state_q == ACK);
    wait_lim  = bus.Slow_Select_H ? SlowW : FastW;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_m1_d   = last_m1_q;
    cnt_d       = cnt_q;
    addr_hold_d = drive_bus ? sel_addr : addr_hold_q;
    dout_hold_d = drive_bus ? sel_dout : dout_hold_q;
    case (state_q)
      IDLE: begin
        grant_d = 2'b00;
        if (req0 && req1) begin
          grant_d = last_m1_q ? 2'b01 : 2'b10;
        end else if (req0) begin
          grant_d = 2'b01;
        end else if (req1) begin
          grant_d = 2'b10;
        end
        if (grant_d != 2'b00) begin
          state_d   = ACCESS;
          cnt_d     = 8'd0;
          last_m1_d = grant_d[1];
        end
      end
      ACCESS: begin
        // Owner dropping its strobe mid-access abandons the transfer without an ACK.
        if (own_as_l) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (32'(cnt_q) + 32'd1 >= wait_lim) begin
            state_d = ACK;
          end
        end
      end
      ACK: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (own_as_l) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      last_m1_q   <= 1'b1;
      cnt_q       <= 8'd0;
      addr_hold_q <= 32'd0;
      dout_hold_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_m1_q   <= last_m1_d;
      cnt_q       <= cnt_d;
      addr_hold_q <= addr_hold_d;
      dout_hold_q <= dout_hold_d;
    end
  end

  // Strobe and acknowledges come only from registered state so they never glitch.
  assign bus.Bus_AS_L        = !drive_bus;
  assign bus.Bus_WE_L        = drive_bus ? sel_we_l : 1'b1;
  assign bus.Bus_Byte_Enable = drive_bus ? sel_be : 4'b0000;
  assign bus.Bus_Address     = drive_bus ? sel_addr : addr_hold_q;
  assign bus.Bus_DataOut     = drive_bus ? sel_dout : dout_hold_q;
  assign bus.Grant           = grant_q;
  assign bus.M0_DTAck_H      = (state_q == ACK) && grant_q[0];
  assign bus.M1_DTAck_H      = (state_q == ACK) && grant_q[1];
  assign bus.M0_DataIn       = grant_q[0] ? bus.Bus_DataIn : 32'd0;
  assign bus.M1_DataIn       = grant_q[1] ? bus.Bus_DataIn : 32'd0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random single/contended transfers
// checked against a timing-rule model (grant next cycle, ACK W cycles later, round-robin ties).
module tb_bus_arbiter;
  localparam int FAST = 1;
  localparam int SLOW = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   last_m;

  logic [31:0] t_addr [2];
  logic [31:0] t_wd   [2];
  logic [3:0]  t_be   [2];
  logic        t_we   [2];
  logic        t_slow [2];

  bus_arbiter_if bif ();

  bus_arbiter #(.FAST_WAIT(FAST), .SLOW_WAIT(SLOW)) dut (
    .Clock  (clk),
    .Reset_L(rst_n),
    .bus    (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int m);
    return (m == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic new_txn(input int m, input logic slow);
    t_addr[m] = $urandom;
    t_wd[m]   = $urandom;
    t_be[m]   = 4'($urandom_range(1, 15));
    t_we[m]   = 1'($urandom_range(0, 1));
    t_slow[m] = slow;
  endtask

  task automatic set_req(input int m, input logic as_l);
    if (m == 0) begin
      bif.M0_AS_L = as_l; bif.M0_WE_L = t_we[0]; bif.M0_Byte_Enable = t_be[0];
      bif.M0_Address = t_addr[0]; bif.M0_DataOut = t_wd[0];
    end else begin
      bif.M1_AS_L = as_l; bif.M1_WE_L = t_we[1]; bif.M1_Byte_Enable = t_be[1];
      bif.M1_Address = t_addr[1]; bif.M1_DataOut = t_wd[1];
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_grant"}, 32'(bif.Grant), 32'd0);
    chk({tag, "_as"}, 32'(bif.Bus_AS_L), 32'd1);
    chk({tag, "_we"}, 32'(bif.Bus_WE_L), 32'd1);
    chk({tag, "_be"}, 32'(bif.Bus_Byte_Enable), 32'd0);
    chk({tag, "_addr"}, bif.Bus_Address, 32'd0);
    chk({tag, "_dout"}, bif.Bus_DataOut, 32'd0);
    chk({tag, "_dtack0"}, 32'(bif.M0_DTAck_H), 32'd0);
    chk({tag, "_dtack1"}, 32'(bif.M1_DTAck_H), 32'd0);
    chk({tag, "_din0"}, bif.M0_DataIn, 32'd0);
    chk({tag, "_din1"}, bif.M1_DataIn, 32'd0);
  endtask

  task automatic chk_release(input int m);
    chk("rel_grant", 32'(bif.Grant), 32'(onehot(m)));
    chk("rel_as", 32'(bif.Bus_AS_L), 32'd1);
    chk("rel_we", 32'(bif.Bus_WE_L), 32'd1);
    chk("rel_dtack0", 32'(bif.M0_DTAck_H), 32'd0);
    chk("rel_dtack1", 32'(bif.M1_DTAck_H), 32'd0);
  endtask

  // Entered in the cycle master m should first appear granted; leaves in the following IDLE cycle.
  task automatic serve(input int m, input int hold, input bit fix_din, input logic [31:0] din);
    int w;
    logic [31:0] d;
    w = t_slow[m] ? SLOW : FAST;
    last_m = m;
    bif.Slow_Select_H = t_slow[m];
    for (int k = 0; k <= w; k++) begin
      if (k > 0) tick();
      d = fix_din ? din : $urandom;
      bif.Bus_DataIn = d;
      #1;
      chk("grant", 32'(bif.Grant), 32'(onehot(m)));
      chk("bus_as", 32'(bif.Bus_AS_L), 32'd0);
      chk("bus_we", 32'(bif.Bus_WE_L), 32'(t_we[m]));
      chk("bus_be", 32'(bif.Bus_Byte_Enable), 32'(t_be[m]));
      chk("bus_addr", bif.Bus_Address, t_addr[m]);
      chk("bus_dout", bif.Bus_DataOut, t_wd[m]);
      chk("dtack_own", 32'(m == 0 ? bif.M0_DTAck_H : bif.M1_DTAck_H), 32'(k == w));
      chk("dtack_other", 32'(m == 0 ? bif.M1_DTAck_H : bif.M0_DTAck_H), 32'd0);
      chk("din_own", (m == 0) ? bif.M0_DataIn : bif.M1_DataIn, d);
      chk("din_other", (m == 0) ? bif.M1_DataIn : bif.M0_DataIn, 32'd0);
    end
    repeat (hold) begin
      tick(); #1;
      chk_release(m);
    end
    set_req(m, 1'b1);
    if (hold == 0) begin
      tick(); #1;
      chk_release(m);
    end
    tick(); #1;
    chk("idle_grant", 32'(bif.Grant), 32'd0);
    chk("idle_as", 32'(bif.Bus_AS_L), 32'd1);
    chk("idle_addr_hold", bif.Bus_Address, t_addr[m]);
    chk("idle_dout_hold", bif.Bus_DataOut, t_wd[m]);
    chk("idle_din0", bif.M0_DataIn, 32'd0);
  endtask

  initial begin
    int w;
    clk = 1'b0; rst_n = 1'b1; checks = 0; failures = 0; last_m = 1;
    for (int i = 0; i < 2; i++) begin
      t_addr[i] = '0; t_wd[i] = '0; t_be[i] = '0; t_we[i] = 1'b1; t_slow[i] = 1'b0;
    end
    set_req(0, 1'b1); set_req(1, 1'b1);
    bif.Bus_DataIn = 32'd0; bif.Slow_Select_H = 1'b0;
    #1 rst_n = 1'b0;
    #2 chk_reset("por");
    tick(); tick();
    rst_n = 1'b1;

    // Contended round-robin: expected order M0, M1, M0, M1.
    new_txn(0, 1'b0); new_txn(1, 1'b0);
    set_req(0, 1'b0); set_req(1, 1'b0);
    for (int r = 0; r < 4; r++) begin
      tick(); #1;
      chk("rr_order", 32'(bif.Grant), 32'(onehot(r % 2)));
      w = 1 - last_m;
      serve(w, 0, 1'b0, 32'd0);
      if (r < 2) begin
        new_txn(w, 1'b0);
        set_req(w, 1'b0);
      end
    end

    // M0 fast read with fixed read data.
    new_txn(0, 1'b0); t_we[0] = 1'b1;
    set_req(0, 1'b0);
    tick();
    serve(0, 0, 1'b1, 32'hDEADBEEF);

    // M1 slow write.
    new_txn(1, 1'b1);
    t_addr[1] = 32'h0040_0010; t_be[1] = 4'b0011; t_we[1] = 1'b0;
    set_req(1, 1'b0);
    tick();
    serve(1, 0, 1'b0, 32'd0);

    // M0 aborts in its second ACCESS cycle while M1 waits.
    new_txn(0, 1'b1); new_txn(1, 1'b1);
    bif.Slow_Select_H = 1'b1;
    set_req(0, 1'b0);
    tick(); #1;
    chk("abort_grant", 32'(bif.Grant), 32'd1);
    last_m = 0;
    set_req(1, 1'b0);
    tick(); #1;
    chk("abort_grant2", 32'(bif.Grant), 32'd1);
    chk("abort_dtack", 32'(bif.M0_DTAck_H), 32'd0);
    set_req(0, 1'b1);
    tick(); #1;
    chk("abort_idle", 32'(bif.Grant), 32'd0);
    chk("abort_no_ack", 32'(bif.M0_DTAck_H), 32'd0);
    tick();
    serve(1, 0, 1'b0, 32'd0);

    // M0 keeps its strobe low 10 cycles past ACK; M1 must wait.
    new_txn(0, 1'b0); new_txn(1, 1'b0);
    set_req(0, 1'b0);
    tick();
    set_req(1, 1'b0);
    serve(0, 10, 1'b0, 32'd0);
    tick();
    serve(1, 0, 1'b0, 32'd0);

    // Reset pulse mid-ACCESS, then a contended restart.
    new_txn(0, 1'b1);
    set_req(0, 1'b0);
    bif.Slow_Select_H = 1'b1;
    tick(); tick();
    rst_n = 1'b0;
    #1 chk_reset("midrst");
    set_req(0, 1'b1);
    tick(); #1;
    chk("rst_hold_grant", 32'(bif.Grant), 32'd0);
    chk("rst_hold_dtack", 32'(bif.M0_DTAck_H), 32'd0);
    tick();
    rst_n = 1'b1;
    last_m = 1;
    new_txn(0, 1'b0); new_txn(1, 1'b0);
    set_req(0, 1'b0); set_req(1, 1'b0);
    tick();
    w = 1 - last_m;
    serve(w, 0, 1'b0, 32'd0);
    tick();
    serve(1 - w, 0, 1'b0, 32'd0);

    // Random single and contended transfers against the model.
    for (int i = 0; i < 25; i++) begin
      int  m;
      bit  both;
      m    = $urandom_range(0, 1);
      both = ($urandom_range(0, 2) == 0);
      new_txn(0, 1'($urandom_range(0, 1)));
      new_txn(1, 1'($urandom_range(0, 1)));
      set_req(m, 1'b0);
      if (both) set_req(1 - m, 1'b0);
      tick();
      w = both ? (1 - last_m) : m;
      serve(w, 0, 1'b0, 32'd0);
      if (both) begin
        tick();
        serve(1 - w, 0, 1'b0, 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
